// File: rtl/rvmemarb_pkg.sv
// ---------------------------------------------------------------------------
// rvmemarb_pkg
// Shared definitions for the two-master memory arbiter:
//   - state_t : sequencer states
//   - MST_I / MST_D : master identifiers (instruction fetch / data)
//   - ADDR_W / DATA_W / MASK_W : default widths
// ---------------------------------------------------------------------------
package rvmemarb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = DATA_W / 8;

  localparam logic MST_I = 1'b0;
  localparam logic MST_D = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_WR_RESP
  } state_t;

endpackage

// File: rtl/rvmemarb_pick.sv
// ---------------------------------------------------------------------------
// rvmemarb_pick
// Grant selection between the instruction and data masters.
//   Default build       : fixed priority, d beats i.
//   RVMEMARB_RR_EN set  : round-robin on ties via a one-bit pointer that
//                         favours the master not granted last (resets to d).
// Ports:
//   clock, reset   (RVMEMARB_RR_EN only) pointer clock / async active-high reset
//   accept_i       (RVMEMARB_RR_EN only) a grant was taken this cycle
//   i_valid_i      instruction master requesting
//   d_valid_i      data master requesting
//   grant_valid_o  some master is requesting
//   grant_id_o     winning master (MST_I / MST_D)
// ---------------------------------------------------------------------------
module rvmemarb_pick
  import rvmemarb_pkg::*;
(
`ifdef RVMEMARB_RR_EN
  input  logic clock,
  input  logic reset,
  input  logic accept_i,
`endif
  input  logic i_valid_i,
  input  logic d_valid_i,
  output logic grant_valid_o,
  output logic grant_id_o
);

  assign grant_valid_o = i_valid_i | d_valid_i;

`ifdef RVMEMARB_RR_EN
  logic favor_d_q, favor_d_d;

  always_comb begin
    grant_id_o = MST_I;
    if (d_valid_i && (!i_valid_i || favor_d_q)) begin
      grant_id_o = MST_D;
    end
  end

  // Whoever wins now loses the next tie.
  always_comb begin
    favor_d_d = favor_d_q;
    if (accept_i) begin
      favor_d_d = (grant_id_o == MST_I);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      favor_d_q <= 1'b1;
    end else begin
      favor_d_q <= favor_d_d;
    end
  end
`else
  assign grant_id_o = d_valid_i ? MST_D : MST_I;
`endif

endmodule

// File: rtl/rvmemarb.sv
// ---------------------------------------------------------------------------
// rvmemarb
// Two-master arbiter/sequencer in front of one split-channel memory.
// Accepts one request at a time (instruction fetch reads, data reads/writes),
// walks the memory's read address/data or write address/data/response
// handshakes, then pulses resp_valid for the owning master for one cycle.
// Optional build macro: RVMEMARB_RR_EN (round-robin grant instead of d-first).
// Ports:
//   clock, reset                  sole clock; async active-high reset
//   i_req_valid/ready/addr        instruction read request
//   i_resp_valid                  instruction read-complete pulse
//   d_req_valid/ready/addr/wr/wdata/wmask  data request
//   d_resp_valid                  data read/write-complete pulse
//   resp_rdata                    read data for whichever master completed
//   mem_addr                      shared memory read/write address
//   mem_waen/mem_wden/mem_wdata/mem_wmask  write address and data phases
//   mem_wardy/mem_wdrdy/mem_wbvld write address ready, data ready, done
//   mem_raen                      read address enable
//   mem_rdata/mem_rardy/mem_rdrdy read data, address ready, data valid
// ---------------------------------------------------------------------------
module rvmemarb
  import rvmemarb_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_W,
  parameter int DATA_WIDTH  = DATA_W,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_req_valid,
  output logic                    i_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  output logic                    i_resp_valid,
  input  logic                    d_req_valid,
  output logic                    d_req_ready,
  input  logic [ADDR_WIDTH-1:0]   d_req_addr,
  input  logic                    d_req_wr,
  input  logic [DATA_WIDTH-1:0]   d_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_req_wmask,
  output logic                    d_resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_waen,
  output logic                    mem_wden,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_wardy,
  input  logic                    mem_wdrdy,
  input  logic                    mem_wbvld,
  output logic                    mem_raen,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rardy,
  input  logic                    mem_rdrdy
);

  // No timeout machinery exists; refuse to elaborate if one is asked for.
  if (MEM_TIMEOUT != 0) begin : g_timeout_unsupported
    $error("rvmemarb: MEM_TIMEOUT must be 0");
  end

  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;
  logic                    owner_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    i_resp_q;
  logic                    d_resp_q;

  logic grant_valid, grant_id;
  logic load_req, rd_done, wr_done;
  logic is_wr;

  rvmemarb_pick u_pick (
`ifdef RVMEMARB_RR_EN
    .clock         (clock),
    .reset         (reset),
    .accept_i      (load_req),
`endif
    .i_valid_i     (i_req_valid),
    .d_valid_i     (d_req_valid),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign is_wr = (grant_id == MST_D) && d_req_wr;

  // NOTE: every signal driven here gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d  = state_q;
    load_req = 1'b0;
    rd_done  = 1'b0;
    wr_done  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          load_req = 1'b1;
          state_d  = is_wr ? ST_WR_ADDR : ST_RD_ADDR;
        end
      end
      ST_RD_ADDR: if (mem_rardy) state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        if (mem_rdrdy) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR: if (mem_wardy) state_d = ST_WR_DATA;
      ST_WR_DATA: if (mem_wdrdy) state_d = ST_WR_RESP;
      ST_WR_RESP: begin
        if (mem_wbvld) begin
          wr_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the latched request fields are reset too, so an aborted
  // transaction leaves nothing stale on the memory-side outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      owner_q  <= MST_I;
      rdata_q  <= '0;
      i_resp_q <= 1'b0;
      d_resp_q <= 1'b0;
    end else begin
      i_resp_q <= rd_done && (owner_q == MST_I);
      d_resp_q <= (rd_done && (owner_q == MST_D)) || wr_done;
      if (rd_done) begin
        rdata_q <= mem_rdata;
      end
      if (load_req) begin
        addr_q  <= (grant_id == MST_D) ? d_req_addr : i_req_addr;
        wdata_q <= is_wr ? d_req_wdata : '0;
        wmask_q <= is_wr ? d_req_wmask : '0;
        owner_q <= grant_id;
      end
    end
  end

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign i_req_ready  = !reset && (state_q == ST_IDLE) && grant_valid && (grant_id == MST_I);
  assign d_req_ready  = !reset && (state_q == ST_IDLE) && grant_valid && (grant_id == MST_D);

  assign i_resp_valid = i_resp_q;
  assign d_resp_valid = d_resp_q;
  assign resp_rdata   = rdata_q;

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign mem_raen  = (state_q == ST_RD_ADDR);
  assign mem_waen  = (state_q == ST_WR_ADDR);
  assign mem_wden  = (state_q == ST_WR_DATA);

endmodule

// File: tb/tb_rvmemarb.sv
// ---------------------------------------------------------------------------
// tb_rvmemarb
// Self-checking bench for rvmemarb against a single-cycle memory model.
// Honours RVMEMARB_RR_EN for the repeated-tie grant order.
// ---------------------------------------------------------------------------
module tb_rvmemarb;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_resp_valid;
  logic        d_req_valid, d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_req_wr;
  logic [31:0] d_req_wdata;
  logic [3:0]  d_req_wmask;
  logic        d_resp_valid;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic        mem_waen, mem_wden, mem_raen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wardy, mem_wdrdy, mem_wbvld;
  logic [31:0] mem_rdata;
  logic        mem_rardy, mem_rdrdy;

  int n_tests = 0;
  int n_fail  = 0;
  int onehot_viol = 0;

  always #5 clock = ~clock;

  rvmemarb dut (
    .clock        (clock),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_resp_valid (i_resp_valid),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_wr     (d_req_wr),
    .d_req_wdata  (d_req_wdata),
    .d_req_wmask  (d_req_wmask),
    .d_resp_valid (d_resp_valid),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_waen     (mem_waen),
    .mem_wden     (mem_wden),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_wardy    (mem_wardy),
    .mem_wdrdy    (mem_wdrdy),
    .mem_wbvld    (mem_wbvld),
    .mem_raen     (mem_raen),
    .mem_rdata    (mem_rdata),
    .mem_rardy    (mem_rardy),
    .mem_rdrdy    (mem_rdrdy)
  );

  // ---- single-cycle memory model: always ready, data/done one cycle later
  assign mem_wardy = 1'b1;
  assign mem_wdrdy = 1'b1;
  assign mem_rardy = 1'b1;

  logic [31:0] mem [256];

  function automatic logic [31:0] init_word(input int k);
    if (k == 'h40) return 32'hDEADBEEF;
    if (k >= 'hC0 && k < 'hC8) return 32'hA5000000 | k;
    return 32'hFFFFFFFF;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 256; k++) mem[k] <= init_word(k);
      mem_rdrdy <= 1'b0;
      mem_wbvld <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_rdrdy <= mem_raen & mem_rardy;
      if (mem_raen & mem_rardy) mem_rdata <= mem[mem_addr[9:2]];
      mem_wbvld <= mem_wden & mem_wdrdy;
      if (mem_wden & mem_wdrdy) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  always @(negedge clock) begin
    if (!reset && (int'(mem_raen) + int'(mem_waen) + int'(mem_wden) > 1)) onehot_viol++;
  end

  // ---- helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;   // resp_rdata expected after the response
    int          lat;     // cycles from accept to resp_valid
  } vec_t;

  // Issue one request from idle and follow it to its response.
  task automatic do_txn(input vec_t v, input string tag);
    int  w, lat;
    bit  got, other;
    logic rdy;
    if (v.is_d) begin
      d_req_valid = 1'b1; d_req_addr = v.addr; d_req_wr = v.wr;
      d_req_wdata = v.wdata; d_req_wmask = v.wmask;
    end else begin
      i_req_valid = 1'b1; i_req_addr = v.addr;
    end
    #1;
    w = 0;
    rdy = v.is_d ? d_req_ready : i_req_ready;
    while (!rdy && w < 20) begin
      tick(); w++;
      rdy = v.is_d ? d_req_ready : i_req_ready;
    end
    check({tag, " ready"}, 64'(rdy), 64'd1);
    tick();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    lat = 1; got = 0; other = 0;
    while (lat <= 12) begin
      if (lat == 1) begin
        check({tag, " mem_addr"}, 64'(mem_addr), 64'(v.addr));
        check({tag, " raen/waen"}, 64'({mem_raen, mem_waen}), v.wr ? 64'd1 : 64'd2);
      end
      if (lat == 2 && v.wr)
        check({tag, " wden/wdata/wmask"}, 64'({mem_wden, mem_wdata, mem_wmask}),
              64'({1'b1, v.wdata, v.wmask}));
      if (v.is_d ? i_resp_valid : d_resp_valid) other = 1;
      if (v.is_d ? d_resp_valid : i_resp_valid) begin
        got = 1;
        break;
      end
      tick(); lat++;
    end
    check({tag, " latency"}, got ? 64'(lat) : 64'd0, 64'(v.lat));
    check({tag, " rdata"}, 64'(resp_rdata), 64'(v.rdata));
    check({tag, " other resp"}, 64'(other), 64'd0);
    tick();
    check({tag, " single pulse"}, 64'(v.is_d ? d_resp_valid : i_resp_valid), 64'd0);
  endtask

  localparam int NV = 7;
  vec_t vecs [NV];

  initial begin
    logic order [3];
    logic exp_order [3];
    int   k, w, cyc, n_acc, n_resp, first_acc, last_resp;
    bit   acc;
    vec_t vr;

    vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, 32'hDEADBEEF, 3};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 32'h11223344, 4'b0101, 32'hDEADBEEF, 4};
    vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'b0000, 32'hFF22FF44, 3};
    vecs[3] = '{1'b1, 1'b1, 32'h204, 32'hCAFEF00D, 4'b1111, 32'hFF22FF44, 4};
    vecs[4] = '{1'b0, 1'b0, 32'h204, 32'h0,        4'b0000, 32'hCAFEF00D, 3};
    vecs[5] = '{1'b1, 1'b1, 32'h208, 32'h12345678, 4'b1000, 32'hCAFEF00D, 4};
    vecs[6] = '{1'b1, 1'b0, 32'h208, 32'h0,        4'b0000, 32'h12FFFFFF, 3};

    // ---- reset state (requests present to prove ready is held low)
    reset = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_wr = 1'b1;
    d_req_wdata = 32'h12345678; d_req_wmask = 4'hF;
    #3;
    check("reset ctrl", 64'({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid,
                              mem_raen, mem_waen, mem_wden}), 64'd0);
    check("reset addr/rdata", 64'({mem_addr, resp_rdata}), 64'd0);
    check("reset wdata/wmask", 64'({mem_wdata, mem_wmask}), 64'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // ---- directed vectors
    for (int i = 0; i < NV; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // ---- simultaneous request: d first, i waits for d's response cycle
    d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_wr = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    #1;
    check("tie d_ready", 64'(d_req_ready), 64'd1);
    check("tie i_ready", 64'(i_req_ready), 64'd0);
    tick();
    d_req_valid = 1'b0;
    for (int c = 1; c < 3; c++) begin
      check($sformatf("tie i_ready c%0d", c), 64'(i_req_ready), 64'd0);
      tick();
    end
    check("tie d_resp", 64'({d_resp_valid, i_resp_valid}), 64'b10);
    check("tie d rdata", 64'(resp_rdata), 64'hDEADBEEF);
    check("tie i_ready at d_resp", 64'(i_req_ready), 64'd1);
    tick();
    i_req_valid = 1'b0;
    tick(); tick();
    check("tie i_resp", 64'({d_resp_valid, i_resp_valid}), 64'b01);
    check("tie i rdata", 64'(resp_rdata), 64'hFF22FF44);
    tick();

    // ---- repeated tie: grant order
`ifdef RVMEMARB_RR_EN
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1;
`else
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
`endif
    d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_wr = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    #1;
    k = 0; w = 0;
    while (k < 3 && w < 40) begin
      if (d_req_ready && i_req_ready) check("both ready", 64'd1, 64'd0);
      if (d_req_ready) begin order[k] = 1'b1; k++; end
      else if (i_req_ready) begin order[k] = 1'b0; k++; end
      tick(); w++;
    end
    d_req_valid = 1'b0; i_req_valid = 1'b0;
    check("rtie grants", 64'(k), 64'd3);
    for (int j = 0; j < 3; j++)
      check($sformatf("rtie grant%0d is_d", j), 64'(k > j ? order[j] : 1'bx), 64'(exp_order[j]));
    for (int j = 0; j < 6; j++) tick();

    // ---- 8 back-to-back i reads with valid held high
    i_req_addr = 32'h300; i_req_valid = 1'b1;
    #1;
    n_acc = 0; n_resp = 0; cyc = 0; first_acc = 0; last_resp = 0;
    while (n_resp < 8 && cyc < 80) begin
      if (i_resp_valid) begin
        check($sformatf("b2b data%0d", n_resp), 64'(resp_rdata), 64'(32'hA50000C0 + n_resp));
        check($sformatf("b2b gap%0d", n_resp),
              64'(cyc - (n_resp == 0 ? first_acc : last_resp)), 64'd3);
        last_resp = cyc;
        n_resp++;
      end
      acc = i_req_ready && (n_acc < 8);
      if (acc) begin
        if (n_acc == 0) first_acc = cyc;
        n_acc++;
      end
      tick(); cyc++;
      if (acc) begin
        if (n_acc == 8) i_req_valid = 1'b0;
        else i_req_addr = 32'h300 + 32'(4 * n_acc);
      end
    end
    i_req_valid = 1'b0;
    check("b2b responses", 64'(n_resp), 64'd8);
    tick();

    // ---- reset in WR_DATA aborts the write
    d_req_valid = 1'b1; d_req_addr = 32'h20C; d_req_wr = 1'b1;
    d_req_wdata = 32'h55AA55AA; d_req_wmask = 4'hF;
    #1;
    check("abort accept", 64'(d_req_ready), 64'd1);
    tick();
    d_req_valid = 1'b0;
    tick();
    check("abort in WR_DATA", 64'(mem_wden), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort ctrl", 64'({i_req_ready, d_req_ready, i_resp_valid, d_resp_valid,
                              mem_raen, mem_waen, mem_wden}), 64'd0);
    check("abort data", 64'({mem_addr, mem_wdata, mem_wmask}), 64'd0);
    tick();
    check("abort no resp 1", 64'(d_resp_valid), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check("abort no resp 2", 64'(d_resp_valid), 64'd0);
    vr = '{1'b0, 1'b0, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF, 3};
    do_txn(vr, "post-reset");

    check("mem enables one-hot", 64'(onehot_viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
